// File: rtl/instr_encoder_pkg.sv
// RV32I opcode/funct3 types shared with the decode path, plus encoder-side
// instruction formats, the NOP word and immediate range limits.
package instr_encoder_pkg;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpOpImm  = 7'b0010011,
        OpAuipc  = 7'b0010111,
        OpStore  = 7'b0100011,
        OpOp     = 7'b0110011,
        OpLui    = 7'b0110111,
        OpBranch = 7'b1100011,
        OpJalr   = 7'b1100111,
        OpJal    = 7'b1101111
    } opcode_type_e;

    typedef enum logic [2:0] {
        F3AddSub = 3'b000,
        F3Sll    = 3'b001,
        F3Slt    = 3'b010,
        F3Sltu   = 3'b011,
        F3Xor    = 3'b100,
        F3Srl    = 3'b101,
        F3Or     = 3'b110,
        F3And    = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        FmtR,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtBad
    } instr_fmt_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } enc_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopWord = 32'h0000_0013;

    localparam int ImmIMin = -2048;
    localparam int ImmIMax = 2047;
    localparam int ImmBMin = -4096;
    localparam int ImmBMax = 4094;
    localparam int ImmJMin = -(1 << 20);
    localparam int ImmJMax = (1 << 20) - 2;

    function automatic instr_fmt_e opcode_fmt(input logic [6:0] op);
        instr_fmt_e fmt;
        case (op)
            OpOp:                   fmt = FmtR;
            OpOpImm, OpLoad, OpJalr: fmt = FmtI;
            OpStore:                fmt = FmtS;
            OpBranch:               fmt = FmtB;
            OpLui, OpAuipc:         fmt = FmtU;
            OpJal:                  fmt = FmtJ;
            default:                fmt = FmtBad;
        endcase
        return fmt;
    endfunction

    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: fields in, {word, illegal} out.
// Legality checks are compiled in only when INSTR_ENC_CHECK_EN is defined.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    instr_fmt_e fmt;
    logic       is_shift;

    always_comb begin
        fmt      = opcode_fmt(opcode);
        is_shift = (opcode == OpOpImm) && ((funct3 == F3Sll) || (funct3 == F3Srl));

        // R layout doubles as the raw packing for unknown opcodes
        word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt)
            FmtI: begin
                if (is_shift) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            FmtS: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FmtB: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FmtU: word = {imm[31:12], rd, opcode};
            FmtJ: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: ;
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    always_comb begin
        illegal = 1'b0;
        case (fmt)
            FmtR: illegal = 1'b0;
            FmtI: begin
                if (is_shift) begin
                    illegal = (imm[31:5] != '0);
                end else begin
                    illegal = !imm_in_range(imm, ImmIMin, ImmIMax);
                end
            end
            FmtS: illegal = !imm_in_range(imm, ImmIMin, ImmIMax);
            FmtB: illegal = !imm_in_range(imm, ImmBMin, ImmBMax) || imm[0];
            FmtU: illegal = (imm[11:0] != '0);
            FmtJ: illegal = !imm_in_range(imm, ImmJMin, ImmJMax) || imm[0];
            default: illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder/loader: packs accepted requests and writes them to
// consecutive imem words. INSTR_ENC_CHECK_EN enables legality checks/NOP substitution.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = NopWord
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   err_idx_o
);

    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   err_idx_q, err_idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic        accept;
    logic [31:0] word;
    logic        illegal;

    instr_pack u_pack (
        .opcode  (opcode_i),
        .funct3  (funct3_i),
        .funct7  (funct7_i),
        .rd      (rd_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .imm     (imm_i),
        .word    (word),
        .illegal (illegal)
    );

    assign accept = (state_q == StLoad) && in_valid_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        idx_d     = idx_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d    = base_addr_i;
                    remain_d  = count_i;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    state_d   = (count_i != '0) ? StLoad : StDone;
                end
            end
            StLoad: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = illegal ? NOP_WORD : word;
                    addr_d    = addr_q + AddrOne;
                    remain_d  = remain_q - CntOne;
                    idx_d     = idx_q + CntOne;
                    if (illegal) begin
                        err_d = 1'b1;
                        // only the first offender of a run is recorded
                        if (!err_q) begin
                            err_idx_d = idx_q;
                        end
                    end
                    if (remain_q == CntOne) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            remain_q  <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready_o = (state_q == StLoad);
    assign busy_o     = (state_q == StLoad);
    assign done_o     = (state_q == StDone);
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign err_o      = err_q;
    assign err_idx_o  = err_idx_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: run-level reference model checked every cycle,
// plus literal expectations for the hand-encoded instruction words.
module tb_instr_encoder;

    localparam int ADDR_W = 10;
`ifdef INSTR_ENC_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic [ADDR_W:0]   count_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [6:0]        opcode_i = '0;
    logic [2:0]        funct3_i = '0;
    logic [6:0]        funct7_i = '0;
    logic [4:0]        rd_i = '0;
    logic [4:0]        rs1_i = '0;
    logic [4:0]        rs2_i = '0;
    logic [31:0]       imm_i = '0;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W:0]   err_idx_o;

    instr_encoder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_idx_o   (err_idx_o)
    );

    initial begin
        forever #5 clk_i = ~clk_i;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the RV32I field layout, via shifts and masks.
    function automatic void model_encode(input logic [31:0] op, input logic [31:0] f3,
                                         input logic [31:0] f7, input logic [31:0] rd,
                                         input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic [31:0] imm,
                                         output logic [31:0] w, output bit ill);
        int v;
        v   = $signed(imm);
        w   = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
        ill = 1'b0;
        case (op)
            32'h13, 32'h03, 32'h67: begin
                if (op == 32'h13 && (f3 == 1 || f3 == 5)) begin
                    w   = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (f7 << 25);
                    ill = (imm >> 5) != 0;
                end else begin
                    w   = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
                    ill = (v < -2048) || (v > 2047);
                end
            end
            32'h23: begin
                w = op | ((imm & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                    | (((imm >> 5) & 127) << 25);
                ill = (v < -2048) || (v > 2047);
            end
            32'h63: begin
                w = op | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12)
                    | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 63) << 25)
                    | (((imm >> 12) & 1) << 31);
                ill = (v < -4096) || (v > 4094) || (v % 2 != 0);
            end
            32'h6F: begin
                w = op | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
                ill = (v < -(1 << 20)) || (v > (1 << 20) - 2) || (v % 2 != 0);
            end
            32'h37, 32'h17: begin
                w   = op | (rd << 7) | (imm & 32'hFFFFF000);
                ill = (imm & 32'hFFF) != 0;
            end
            32'h33:  ill = 1'b0;
            default: ill = 1'b1;
        endcase
        if (!CheckEn) ill = 1'b0;
    endfunction

    // Run-level model: expected outputs for the cycle after each clock edge.
    bit                m_active = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_remain = 0;
    int                m_idx = 0;
    bit                exp_wr_en = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0]       exp_data = '0;
    bit                exp_done = 1'b0;
    bit                exp_busy = 1'b0;
    bit                exp_err = 1'b0;
    int                exp_err_idx = 0;

    task automatic model_step();
        logic [31:0] w;
        bit ill;
        bit was_done;
        was_done  = exp_done;
        exp_wr_en = 1'b0;
        exp_done  = 1'b0;
        if (m_active) begin
            if (in_valid_i) begin
                model_encode(32'(opcode_i), 32'(funct3_i), 32'(funct7_i), 32'(rd_i),
                             32'(rs1_i), 32'(rs2_i), imm_i, w, ill);
                exp_wr_en = 1'b1;
                exp_addr  = m_addr;
                exp_data  = ill ? Nop : w;
                m_addr    = m_addr + 10'd1;
                if (ill && !exp_err) exp_err_idx = m_idx;
                if (ill) exp_err = 1'b1;
                m_idx++;
                m_remain--;
                if (m_remain == 0) begin
                    m_active = 1'b0;
                    exp_done = 1'b1;
                end
            end
        end else if (start_i && !was_done) begin
            m_addr      = base_addr_i;
            m_remain    = int'(count_i);
            m_idx       = 0;
            exp_err     = 1'b0;
            exp_err_idx = 0;
            if (m_remain == 0) exp_done = 1'b1;
            else m_active = 1'b1;
        end
        exp_busy = m_active;
    endtask

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                m_active    = 1'b0;
                m_addr      = '0;
                m_remain    = 0;
                m_idx       = 0;
                exp_wr_en   = 1'b0;
                exp_addr    = '0;
                exp_data    = '0;
                exp_done    = 1'b0;
                exp_busy    = 1'b0;
                exp_err     = 1'b0;
                exp_err_idx = 0;
            end else begin
                model_step();
            end
        end
    end

    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    initial begin
        forever begin
            @(negedge clk_i);
            check("wr_en", 32'(wr_en_o), 32'(exp_wr_en));
            if (exp_wr_en) begin
                check("wr_addr", 32'(wr_addr_o), 32'(exp_addr));
                check("wr_data", wr_data_o, exp_data);
            end
            check("done", 32'(done_o), 32'(exp_done));
            check("busy", 32'(busy_o), 32'(exp_busy));
            check("in_ready", 32'(in_ready_o), 32'(exp_busy));
            check("err", 32'(err_o), 32'(exp_err));
            check("err_idx", 32'(err_idx_o), exp_err_idx);
            if (wr_en_o === 1'b1) begin
                log_addr.push_back(wr_addr_o);
                log_data.push_back(wr_data_o);
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
        log_addr.delete();
        log_data.delete();
        start_i     = 1'b1;
        base_addr_i = base;
        count_i     = cnt;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int n = 0;
        opcode_i   = op;
        funct3_i   = f3;
        funct7_i   = f7;
        rd_i       = rd;
        rs1_i      = rs1;
        rs2_i      = rs2;
        imm_i      = imm;
        in_valid_i = 1'b1;
        while (in_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("send ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check({name, " done"}, 32'(done_o), 32'd1);
        @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] w;
        bit ill;

        // Pin the model against hand-encoded words.
        model_encode(32'h13, 0, 0, 1, 0, 0, 32'd5, w, ill);
        check("model addi", w, 32'h0050_0093);
        model_encode(32'h37, 0, 0, 2, 0, 0, 32'h1234_5000, w, ill);
        check("model lui", w, 32'h1234_5137);
        model_encode(32'h63, 0, 0, 0, 1, 2, -32'sd4, w, ill);
        check("model beq", w, 32'hFE20_8EE3);
        model_encode(32'h6F, 0, 0, 1, 0, 0, 32'd2048, w, ill);
        check("model jal", w, 32'h0010_00EF);
        model_encode(32'h13, 5, 32'h20, 5, 6, 0, 32'd3, w, ill);
        check("model srai", w, 32'h4033_5293);
        model_encode(32'h13, 0, 0, 0, 0, 0, 32'd2048, w, ill);
        check("model addi2048 illegal", 32'(ill), 32'(CheckEn));

        repeat (3) @(negedge clk_i);
        check("reset wr_en", 32'(wr_en_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single addi
        do_start(10'h010, 11'd1);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid_i = 1'b0;
        wait_done("t1");
        check("t1 nwr", 32'(log_data.size()), 32'd1);
        check("t1 addr", 32'(log_addr[0]), 32'h010);
        check("t1 data", log_data[0], 32'h0050_0093);
        check("t1 err", 32'(err_o), 32'd0);

        // back-to-back lui/beq/jal
        do_start(10'h020, 11'd3);
        send(7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5000);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        in_valid_i = 1'b0;
        wait_done("t2");
        check("t2 nwr", 32'(log_data.size()), 32'd3);
        check("t2 addr2", 32'(log_addr[2]), 32'h022);
        check("t2 lui", log_data[0], 32'h1234_5137);
        check("t2 beq", log_data[1], 32'hFE20_8EE3);
        check("t2 jal", log_data[2], 32'h0010_00EF);

        // out-of-range immediates
        do_start(10'h040, 11'd2);
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        in_valid_i = 1'b0;
        wait_done("t3");
        check("t3 data0", log_data[0], CheckEn ? Nop : 32'h8000_0013);
        check("t3 data1", log_data[1], CheckEn ? Nop : 32'h0000_0163);
        check("t3 err", 32'(err_o), 32'(CheckEn));
        check("t3 err_idx", 32'(err_idx_o), 32'd0);

        // address wrap
        do_start(10'h3FF, 11'd2);
        send(7'h13, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3);
        send(7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, -32'sd8);
        in_valid_i = 1'b0;
        wait_done("t4");
        check("t4 addr0", 32'(log_addr[0]), 32'h3FF);
        check("t4 addr1", 32'(log_addr[1]), 32'h000);
        check("t4 srai", log_data[0], 32'h4033_5293);
        check("t4 sw", log_data[1], 32'hFE31_2C23);
        check("t4 err cleared", 32'(err_o), 32'd0);

        // empty run
        do_start(10'h100, 11'd0);
        wait_done("t5");
        check("t5 nwr", 32'(log_data.size()), 32'd0);

        // reset in the middle of a 5-request run
        do_start(10'h200, 11'd5);
        send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        opcode_i = 7'h13;
        #2 rst_ni = 1'b0;
        #1;
        check("rst wr_en", 32'(wr_en_o), 32'd0);
        check("rst wr_addr", 32'(wr_addr_o), 32'd0);
        check("rst wr_data", wr_data_o, 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst ready", 32'(in_ready_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        in_valid_i = 1'b0;
        check("t6 nwr", 32'(log_data.size()), 32'd2);
        check("t6 add", log_data[1], 32'h0020_81B3);

        do_start(10'h300, 11'd1);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid_i = 1'b0;
        wait_done("t7");
        check("t7 addr", 32'(log_addr[0]), 32'h300);
        check("t7 data", log_data[0], 32'h0050_0093);

        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder and loader: accepts decoded fields (opcode, funct3, funct7, rd, rs1, rs2, 32-bit immediate) over a valid/ready handshake.
- Packs each request into a 32-bit instruction word, checks immediate legality, and writes the words to consecutive instruction-memory addresses.
- Inverse of the immediate/field decode path; used by the self-test program loader and by verification to build imem images in-system.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory write port.
- NOP_WORD, 32'h0000_0013, word substituted for an illegal request (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- start_i  in  1  one-cycle pulse; begins a load run.
- base_addr_i  in  ADDR_W  first word address of the run; sampled on start.
- count_i  in  ADDR_W+1  number of instructions in the run; sampled on start.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- opcode_i  in  7  opcode_type_e value.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field (R-type, shift-immediates).
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- imm_i  in  32  full signed immediate (byte offset for B/J; upper value with low 12 bits zero for LUI/AUIPC).
- wr_en_o  out  1  imem write strobe.
- wr_addr_o  out  ADDR_W  imem word address.
- wr_data_o  out  32  encoded instruction.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at run completion.
- err_o  out  1  sticky; some request in the current run was illegal.
- err_idx_o  out  ADDR_W+1  index within the run of the first illegal request.

Behaviour:
- Reset (async, rst_ni low): state IDLE; all outputs 0; address and remaining counters 0. Reset mid-run aborts immediately; no further writes occur.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: on start_i, capture base_addr_i and count_i, clear err_o/err_idx_o. Go to LOAD if count>0, else DONE.
  - LOAD: in_ready_o=1. Each accept decrements remaining. Accept of the last request goes to DONE.
  - DONE: one cycle; done_o=1, busy_o=0; then IDLE.
- start_i is ignored outside IDLE.
- in_ready_o is 0 in IDLE and DONE.
- busy_o=1 in LOAD only.
- Latency: a request accepted in cycle N produces wr_en_o=1 in cycle N+1 with registered wr_addr_o/wr_data_o.
  - The memory always accepts, so throughput is 1 word/cycle.
  - wr_en_o for the last request coincides with done_o.
- wr_addr_o starts at base and increments by 1 per write, wrapping modulo 2^ADDR_W.
- Encoding:
  - Standard RV32I field placement per opcode.
  - R-type uses funct7/rs2/rs1/funct3/rd.
  - I-type shifts (funct3 001/101) place funct7_i in [31:25] and imm_i[4:0] in [24:20].
  - Fields not used by a format are ignored.
- Legality (checks enabled):
  - I/Load/JALR/Store: -2048..2047.
  - Shift-immediate: imm_i[31:5]==0.
  - B: -4096..4094 and even.
  - JAL: -2^20..2^20-2 and even.
  - LUI/AUIPC: imm_i[11:0]==0.
  - R-type: imm_i ignored.
  - Any opcode not in opcode_type_e is illegal.
- Illegal request:
  - NOP_WORD is written at that address (address still advances).
  - err_o set; err_idx_o captures the 0-based run index only if err_o was previously clear.

Optional Feature:
- Macro INSTR_ENC_CHECK_EN.
- Defined: legality checking, NOP substitution, err_o/err_idx_o as above.
- Undefined:
  - No checks; immediates are truncated/bit-selected into fields as-is.
  - Unknown opcodes emit {funct7,rs2,rs1,funct3,rd,opcode}.
  - err_o and err_idx_o are tied 0.

Decomposition:
- Extend the shared opcode_type package with:
  - instruction-format enum (R,I,S,B,U,J);
  - NOP constant;
  - immediate range localparams.
- Reuse opcode_type_e/funct3_e from that package.
- One combinational sub-module, instr_pack: fields in -> {word, illegal}, containing format select, bit packing and range checks.
- The top holds the FSM, counters, error capture and output registers.

Test Plan:
- start, base=0x010, count=1; addi rd=1 rs1=0 imm=5 -> wr_en at addr 0x010, data 0x00500093; done_o in same cycle; err_o=0.
- count=3, requests:
  - lui rd=2 imm=0x12345000 -> 0x12345137;
  - beq rs1=1 rs2=2 imm=-4 -> 0xFE208EE3;
  - jal rd=1 imm=2048 -> 0x001000EF.
  - Expect back-to-back writes at base..base+2 and done_o with the third write.
- count=2:
  - addi imm=2048 (idx 0) -> 0x00000013 written, err_o=1, err_idx_o=0;
  - beq imm=3 (idx 1) -> NOP written, err_idx_o stays 0.
- base=0x3FF (ADDR_W=10), count=2 -> writes at 0x3FF then 0x000.
- start with count=0 -> no wr_en; done_o one cycle later.
- Deassert rst_ni after 2 of 5 accepts -> all outputs 0 immediately, state IDLE, no further writes; a new start works normally.
